// File: rtl/panda_pkg.sv
// Shared constants and types for the panda position/event fabric.
// Position words are fixed at 32 bits.
package panda_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] pos_t;

  localparam pos_t STEP_RST = pos_t'(1);

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers the previous sample of a level
// and flags a 0->1 transition in the current cycle.
module edge_detect (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      din_d <= 1'b0;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/panda_counter.sv
// Up/down pulse counter with programmable step, preload and
// one-cycle carry/borrow pulse on 32-bit wrap.
module panda_counter
  import panda_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        trigger_i,
  input  logic        DIR,
  input  pos_t        START,
  input  logic        START_LOAD,
  input  pos_t        STEP,
  input  logic        STEP_WSTB,
  output logic        carry_o,
  output pos_t        out_o
);

  pos_t            count;
  pos_t            step_r;
  logic            carry;
  logic            en_rise;
  logic            tr_rise;
  logic [DATA_W:0] sum;
  pos_t            diff;
  logic            borrow;

  edge_detect u_en_edge (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .din       (enable_i),
    .rise      (en_rise)
  );

  edge_detect u_tr_edge (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .din       (trigger_i),
    .rise      (tr_rise)
  );

  assign sum    = {1'b0, count} + {1'b0, step_r};
  assign diff   = count - step_r;
  assign borrow = step_r > count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count  <= '0;
      step_r <= STEP_RST;
      carry  <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (STEP_WSTB) begin
        step_r <= STEP;
      end
      // Loads win over any coincident trigger rise
      if (START_LOAD || en_rise) begin
        count <= START;
      end else if (enable_i && tr_rise) begin
        if (!DIR) begin
          count <= sum[DATA_W-1:0];
          carry <= sum[DATA_W];
        end else begin
          count <= diff;
          carry <= borrow;
        end
      end
    end
  end

  assign out_o   = count;
  assign carry_o = carry;

endmodule

// File: tb/tb_panda_counter.sv
// Self-checking bench for panda_counter: directed scenarios
// plus randomized traffic against an arithmetic reference model.
module tb_panda_counter;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        trigger_i = 1'b0;
  logic        DIR = 1'b0;
  logic [31:0] START = '0;
  logic        START_LOAD = 1'b0;
  logic [31:0] STEP = '0;
  logic        STEP_WSTB = 1'b0;
  logic        carry_o;
  logic [31:0] out_o;

  int errors = 0;
  int checks = 0;

  longint unsigned m_count;
  longint unsigned m_step;
  bit              m_carry;
  bit              m_en_d;
  bit              m_tr_d;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  panda_counter dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .enable_i   (enable_i),
    .trigger_i  (trigger_i),
    .DIR        (DIR),
    .START      (START),
    .START_LOAD (START_LOAD),
    .STEP       (STEP),
    .STEP_WSTB  (STEP_WSTB),
    .carry_o    (carry_o),
    .out_o      (out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_count = 0;
    m_step  = 1;
    m_carry = 0;
    m_en_d  = 0;
    m_tr_d  = 0;
  endtask

  // One clock: model advances from the inputs seen at the edge
  task automatic tick();
    longint unsigned s;
    bit er;
    bit tr;
    @(posedge clk_i);
    if (reset_n_i) begin
      er = enable_i && !m_en_d;
      tr = trigger_i && !m_tr_d;
      m_carry = 0;
      if (START_LOAD || er) begin
        m_count = START;
      end else if (enable_i && tr) begin
        if (!DIR) begin
          s = m_count + m_step;
          m_carry = (s >= MOD);
          m_count = s % MOD;
        end else begin
          m_carry = (m_step > m_count);
          m_count = (m_count + MOD - m_step) % MOD;
        end
      end
      m_en_d = enable_i;
      m_tr_d = trigger_i;
      if (STEP_WSTB) m_step = STEP;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    model_reset();
    #12;
    checks++;
    if (out_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_out got=%h want=0", out_o);
    end
    checks++;
    if (carry_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_carry got=%b want=0", carry_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_count_up();
    logic [31:0] exp_v [4];
    exp_v = '{32'd100, 32'd105, 32'd110, 32'd115};
    @(negedge clk_i);
    START = 32'd100;
    START_LOAD = 1'b1;
    STEP = 32'd5;
    STEP_WSTB = 1'b1;
    enable_i = 1'b1;
    DIR = 1'b0;
    tick();
    START_LOAD = 1'b0;
    STEP_WSTB = 1'b0;
    checks++;
    if (out_o !== exp_v[0] || carry_o !== 1'b0) begin
      errors++;
      $display("FAIL up_load got=%0d/%b want=%0d/0",
               out_o, carry_o, exp_v[0]);
    end
    for (int i = 1; i < 4; i++) begin
      trigger_i = 1'b1;
      tick();
      checks++;
      if (out_o !== exp_v[i] || carry_o !== 1'b0) begin
        errors++;
        $display("FAIL up_step%0d got=%0d/%b want=%0d/0",
                 i, out_o, carry_o, exp_v[i]);
      end
      trigger_i = 1'b0;
      tick();
      checks++;
      if (out_o !== exp_v[i]) begin
        errors++;
        $display("FAIL up_hold%0d got=%0d want=%0d",
                 i, out_o, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap_down();
    enable_i = 1'b0;
    tick();
    DIR = 1'b1;
    START = 32'd2;
    STEP = 32'd3;
    STEP_WSTB = 1'b1;
    tick();
    STEP_WSTB = 1'b0;
    enable_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 32'd2 || carry_o !== 1'b0) begin
      errors++;
      $display("FAIL down_preload got=%h/%b want=2/0",
               out_o, carry_o);
    end
    trigger_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 32'hFFFF_FFFF || carry_o !== 1'b1) begin
      errors++;
      $display("FAIL down_borrow got=%h/%b want=ffffffff/1",
               out_o, carry_o);
    end
    trigger_i = 1'b0;
    tick();
    checks++;
    if (out_o !== 32'hFFFF_FFFF || carry_o !== 1'b0) begin
      errors++;
      $display("FAIL down_pulse got=%h/%b want=ffffffff/0",
               out_o, carry_o);
    end
  endtask

  task automatic test_wrap_up();
    DIR = 1'b0;
    START = 32'hFFFF_FFFE;
    START_LOAD = 1'b1;
    STEP = 32'd1;
    STEP_WSTB = 1'b1;
    tick();
    START_LOAD = 1'b0;
    STEP_WSTB = 1'b0;
    trigger_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 32'hFFFF_FFFF || carry_o !== 1'b0) begin
      errors++;
      $display("FAIL up_top got=%h/%b want=ffffffff/0",
               out_o, carry_o);
    end
    trigger_i = 1'b0;
    tick();
    trigger_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 32'h0 || carry_o !== 1'b1) begin
      errors++;
      $display("FAIL up_carry got=%h/%b want=0/1",
               out_o, carry_o);
    end
    trigger_i = 1'b0;
    tick();
    checks++;
    if (carry_o !== 1'b0) begin
      errors++;
      $display("FAIL up_carry_len got=%b want=0", carry_o);
    end
  endtask

  task automatic test_disabled();
    logic [31:0] v0;
    v0 = out_o;
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      tick();
    end
    checks++;
    if (out_o !== v0) begin
      errors++;
      $display("FAIL disabled_hold got=%h want=%h", out_o, v0);
    end
    START = 32'd7777;
    enable_i = 1'b1;
    trigger_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 32'd7777 || carry_o !== 1'b0) begin
      errors++;
      $display("FAIL en_vs_trig got=%0d/%b want=7777/0",
               out_o, carry_o);
    end
  endtask

  task automatic test_held_trigger();
    logic [31:0] v0;
    trigger_i = 1'b0;
    tick();
    v0 = out_o;
    trigger_i = 1'b1;
    repeat (10) tick();
    checks++;
    if (out_o !== v0 + 32'd1) begin
      errors++;
      $display("FAIL held_trig got=%0d want=%0d", out_o, v0 + 1);
    end
    trigger_i = 1'b0;
    tick();
    START = 32'd555;
    START_LOAD = 1'b1;
    trigger_i = 1'b1;
    tick();
    START_LOAD = 1'b0;
    checks++;
    if (out_o !== 32'd555 || carry_o !== 1'b0) begin
      errors++;
      $display("FAIL load_vs_trig got=%0d/%b want=555/0",
               out_o, carry_o);
    end
    trigger_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    STEP = 32'd9;
    STEP_WSTB = 1'b1;
    START = 32'd42;
    START_LOAD = 1'b1;
    tick();
    STEP_WSTB = 1'b0;
    START_LOAD = 1'b0;
    checks++;
    if (out_o !== 32'd42) begin
      errors++;
      $display("FAIL rst_pre got=%0d want=42", out_o);
    end
    #2;
    reset_n_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_o !== 32'd0 || carry_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got=%h/%b want=0/0",
               out_o, carry_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 32'd42) begin
      errors++;
      $display("FAIL rst_preload got=%0d want=42", out_o);
    end
    trigger_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 32'd43) begin
      errors++;
      $display("FAIL rst_step got=%0d want=43", out_o);
    end
    trigger_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      enable_i   = ($urandom_range(0, 9) != 0);
      trigger_i  = $urandom_range(0, 1);
      DIR        = $urandom_range(0, 1);
      START      = ($urandom_range(0, 1) != 0) ?
                   $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 31);
      START_LOAD = ($urandom_range(0, 15) == 0);
      STEP       = ($urandom_range(0, 3) == 0) ?
                   $urandom : $urandom_range(0, 3);
      STEP_WSTB  = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (out_o !== m_count[31:0] || carry_o !== m_carry) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand%0d got=%h/%b want=%h/%b",
                   i, out_o, carry_o, m_count[31:0], m_carry);
      end
    end
    START_LOAD = 1'b0;
    STEP_WSTB = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_wrap_down();
    test_wrap_up();
    test_disabled();
    test_held_trigger();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
